result_queue: RTL and testbench

- Multi-producer, single-consumer FIFO that collects execution results from N functional-unit write-back ports.
- Emits results one per cycle toward the completion/commit stage (ROB update).
- Each side uses the codebase Message handshake: en = valid, msg = payload, reject = backpressure.
- Simultaneous writes from several ports are serialized in port-index order.

---
 rtl/result_queue_pkg.sv | 13 +
 rtl/result_queue_compact.sv | 25 ++
 rtl/result_queue.sv | 101 ++++++++++
 tb/tb_result_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_queue_pkg.sv
// Shared types for the result queue: the Result payload and its width.
// Both sides use the Message handshake: en = valid, msg = payload, reject = backpressure.
package result_queue_pkg;

  typedef struct packed {
    logic [7:0]  tag;   // ROB index
    logic [31:0] data;
    logic        exc;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/result_queue_compact.sv
// Prefix-count compactor: maps the accepted-port vector to dense write offsets
// (ascending port index) and the total number of accepted ports.
module result_queue_compact #(
  parameter int N_PORTS = 2,
  parameter int OFF_W   = 3,
  parameter int CNT_W   = 4
) (
  input  logic [N_PORTS-1:0]            en_i,
  output logic [N_PORTS-1:0][OFF_W-1:0] offset_o,
  output logic [CNT_W-1:0]              total_o
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      offset_o[i] = acc[OFF_W-1:0];
      acc         = acc + CNT_W'(en_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/result_queue.sv
// Multi-producer, single-consumer result FIFO feeding the commit stage.
// Optional empty-queue bypass to the consumer is enabled by RESULT_QUEUE_BYPASS_EN.
module result_queue
  import result_queue_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int DEPTH   = 8
) (
  input  logic                        clock,
  input  logic                        flash,
  input  logic [N_PORTS-1:0]          r_en,
  input  logic [N_PORTS*RESULT_W-1:0] r_msg,
  output logic [N_PORTS-1:0]          r_reject,
  output logic                        c_en,
  output logic [RESULT_W-1:0]         c_msg,
  input  logic                        c_reject
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RESULT_W-1:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]               head_q, head_d;
  logic [PTR_W-1:0]               tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           full_rej;
  logic                           stored_valid;
  logic                           pop;
  logic [N_PORTS-1:0]             push_vec;
  logic [N_PORTS-1:0][PTR_W-1:0]  push_off;
  logic [CNT_W-1:0]               push_cnt;

  // Conservative: reject all ports unless every port could be stored this cycle.
  assign full_rej     = (CNT_W'(DEPTH) - count_q) < CNT_W'(N_PORTS);
  assign r_reject     = {N_PORTS{full_rej}};
  assign stored_valid = (count_q != '0);
  assign pop          = stored_valid && !c_reject;

`ifdef RESULT_QUEUE_BYPASS_EN
  logic [N_PORTS-1:0]  byp_sel;
  logic [RESULT_W-1:0] byp_msg;
  logic                byp_valid;
  logic                byp_take;

  assign byp_sel   = r_en & (~r_en + N_PORTS'(1));
  assign byp_valid = !stored_valid && (|r_en);
  assign byp_take  = byp_valid && !c_reject;

  always_comb begin
    byp_msg = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (byp_sel[i]) byp_msg = byp_msg | r_msg[i*RESULT_W +: RESULT_W];
    end
  end

  // A bypassed result is consumed directly and never occupies a slot.
  assign push_vec = r_en & ~r_reject & ~(byp_take ? byp_sel : '0);
  assign c_en     = stored_valid | byp_valid;
  assign c_msg    = stored_valid ? mem_q[head_q] : byp_msg;
`else
  assign push_vec = r_en & ~r_reject;
  assign c_en     = stored_valid;
  assign c_msg    = mem_q[head_q];
`endif

  result_queue_compact #(
    .N_PORTS (N_PORTS),
    .OFF_W   (PTR_W),
    .CNT_W   (CNT_W)
  ) u_compact (
    .en_i     (push_vec),
    .offset_o (push_off),
    .total_o  (push_cnt)
  );

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + push_cnt[PTR_W-1:0];
    count_d = count_q + push_cnt - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge flash) begin
    if (!flash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (push_vec[i]) mem_q[tail_q + push_off[i]] <= r_msg[i*RESULT_W +: RESULT_W];
    end
  end

endmodule

// File: tb/tb_result_queue.sv
// Self-checking bench for result_queue (N_PORTS=2, DEPTH=8), scoreboard driven.
module tb_result_queue;
  import result_queue_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;

  logic                  clock = 1'b0;
  logic                  flash = 1'b0;
  logic [N-1:0]          r_en = '0;
  logic [N*RESULT_W-1:0] r_msg = '0;
  logic [N-1:0]          r_reject;
  logic                  c_en;
  logic [RESULT_W-1:0]   c_msg;
  logic                  c_reject = 1'b0;

  result_queue #(.N_PORTS(N), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .flash    (flash),
    .r_en     (r_en),
    .r_msg    (r_msg),
    .r_reject (r_reject),
    .c_en     (c_en),
    .c_msg    (c_msg),
    .c_reject (c_reject)
  );

  always #5 clock = ~clock;

  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  tag_ctr  = 1;
  int                  mdl_tail = 0;
  logic [RESULT_W-1:0] exp_q[$];
  logic                exp_cen;
  logic [RESULT_W-1:0] exp_cmsg;
  logic [N-1:0]        exp_rej;
  logic [N-1:0]        cur_en;
  logic                cur_crej;
  result_t             cur_m0, cur_m1;

  function automatic result_t mk(input int tag);
    result_t r;
    r.tag  = 8'(tag);
    r.data = 32'(tag) * 32'h0101_0101 ^ 32'h5A5A_0000;
    r.exc  = (tag % 3) == 0;
    return r;
  endfunction

  // Apply one cycle of stimulus and derive the expected outputs from the model.
  task automatic drive(input logic [N-1:0] en, input result_t m0, input result_t m1,
                       input logic crej);
    cur_en = en; cur_m0 = m0; cur_m1 = m1; cur_crej = crej;
    r_en = en; r_msg = {m1, m0}; c_reject = crej;
    exp_rej = ((DEPTH - exp_q.size()) < N) ? '1 : '0;
    exp_cen = 1'b0;
    exp_cmsg = '0;
    if (exp_q.size() != 0) begin
      exp_cen = 1'b1; exp_cmsg = exp_q[0];
    end
`ifdef RESULT_QUEUE_BYPASS_EN
    else if (en != '0) begin
      exp_cen = 1'b1; exp_cmsg = en[0] ? m0 : m1;
    end
`endif
    #1;
  endtask

  // Advance the scoreboard by one clock; reports which ports the model accepted.
  task automatic commit(output logic [N-1:0] acc);
    logic [N-1:0] store;
    acc   = cur_en & ~exp_rej;
    store = acc;
`ifdef RESULT_QUEUE_BYPASS_EN
    if (exp_q.size() == 0 && cur_en != '0 && !cur_crej) begin
      if (cur_en[0]) store[0] = 1'b0; else store[1] = 1'b0;
    end
`endif
    if (exp_q.size() != 0 && !cur_crej) void'(exp_q.pop_front());
    if (store[0]) begin exp_q.push_back(cur_m0); mdl_tail = (mdl_tail + 1) % DEPTH; end
    if (store[1]) begin exp_q.push_back(cur_m1); mdl_tail = (mdl_tail + 1) % DEPTH; end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (c_en !== 1'b0) begin n_fail++; $display("FAIL reset c_en: got %b want 0", c_en); end
    n_checks++; if (r_reject !== 2'b00) begin n_fail++; $display("FAIL reset r_reject: got %b want 00", r_reject); end
    #2 flash = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (c_en !== 1'b0) begin n_fail++; $display("FAIL reset_release c_en: got %b want 0", c_en); end
  endtask

  task automatic test_two_ports();
    logic [N-1:0] acc;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 0) drive(2'b11, result_t'{8'd1, 32'd0, 1'b0}, result_t'{8'd2, 32'd0, 1'b0}, 1'b0);
      else          drive(2'b00, '0, '0, 1'b0);
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL two_ports c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL two_ports c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      n_checks++; if (r_reject !== exp_rej) begin n_fail++; $display("FAIL two_ports r_reject cyc%0d: got %b want %b", cyc, r_reject, exp_rej); end
      commit(acc);
    end
  endtask

  task automatic test_port_order();
    logic [N-1:0] acc;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 0)      drive(2'b10, '0, mk(5), 1'b0);
      else if (cyc == 1) drive(2'b01, mk(6), '0, 1'b0);
      else               drive(2'b00, '0, '0, 1'b0);
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL port_order c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL port_order c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      commit(acc);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] acc;
    logic [N-1:0] pend;
    result_t      p0, p1;
    // Two-port fill with the consumer stalled, then a held push while full.
    tag_ctr = 1;
    pend = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (pend == '0 && tag_ctr <= 10) begin
        pend = 2'b11; p0 = mk(tag_ctr); p1 = mk(tag_ctr + 1); tag_ctr += 2;
      end
      drive(pend, p0, p1, cyc < 6 ? 1'b1 : 1'b0);
      n_checks++; if (r_reject !== exp_rej) begin n_fail++; $display("FAIL bp_fill r_reject cyc%0d: got %b want %b", cyc, r_reject, exp_rej); end
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL bp_fill c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL bp_fill c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      commit(acc);
      pend = pend & ~acc;
    end
    // Single-port fill to seven entries: one free slot still rejects both ports.
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 7)       drive(2'b01, mk(tag_ctr + cyc), '0, 1'b1);
      else if (cyc == 7) drive(2'b10, '0, mk(99), 1'b1);
      else               drive(2'b00, '0, '0, 1'b0);
      n_checks++; if (r_reject !== exp_rej) begin n_fail++; $display("FAIL bp_seven r_reject cyc%0d: got %b want %b", cyc, r_reject, exp_rej); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL bp_seven c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL bp_seven c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      commit(acc);
    end
    tag_ctr += 7;
  endtask

  task automatic test_wrap();
    logic [N-1:0] acc;
    logic [N-1:0] pend;
    logic         crej;
    result_t      p0, p1;
    pend = '0;
    // Steer the tail to the last slot so a two-port push straddles the end.
    for (int cyc = 0; cyc < 12 && mdl_tail != DEPTH - 1; cyc++) begin
      drive(2'b01, mk(tag_ctr), '0, 1'b0);
      tag_ctr++;
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL wrap_align c_en: got %b want %b", c_en, exp_cen); end
      commit(acc);
    end
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (cyc == 0) begin
        pend = 2'b11; p0 = mk(200); p1 = mk(201); crej = 1'b0;
      end else if (cyc < 90) begin
        if (!pend[0] && $urandom_range(0, 1) == 1) begin pend[0] = 1'b1; p0 = mk(tag_ctr); tag_ctr++; end
        if (!pend[1] && $urandom_range(0, 1) == 1) begin pend[1] = 1'b1; p1 = mk(tag_ctr); tag_ctr++; end
        crej = ($urandom_range(0, 3) == 0);
      end else begin
        crej = 1'b0;
      end
      drive(pend, p0, p1, crej);
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL wrap c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL wrap c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      n_checks++; if (r_reject !== exp_rej) begin n_fail++; $display("FAIL wrap r_reject cyc%0d: got %b want %b", cyc, r_reject, exp_rej); end
      commit(acc);
      pend = pend & ~acc;
    end
    n_checks++; if (exp_q.size() != 0 || pend != '0) begin n_fail++; $display("FAIL wrap_drain: left %0d entries, pend %b, want 0", exp_q.size(), pend); end
  endtask

  task automatic test_flash();
    logic [N-1:0] acc;
    drive(2'b11, mk(40), mk(41), 1'b1); commit(acc);
    drive(2'b01, mk(42), '0, 1'b1);     commit(acc);
    drive(2'b00, '0, '0, 1'b1);
    n_checks++; if (c_en !== 1'b1) begin n_fail++; $display("FAIL flash_pre c_en: got %b want 1", c_en); end
    #2 flash = 1'b0;
    #1;
    n_checks++; if (c_en !== 1'b0) begin n_fail++; $display("FAIL flash_async c_en: got %b want 0", c_en); end
    n_checks++; if (r_reject !== 2'b00) begin n_fail++; $display("FAIL flash_async r_reject: got %b want 00", r_reject); end
    exp_q.delete();
    mdl_tail = 0;
    r_en = 2'b11; r_msg = {mk(50), mk(51)}; c_reject = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (c_en !== 1'b0) begin n_fail++; $display("FAIL flash_held c_en: got %b want 0", c_en); end
    #2 flash = 1'b1;
    r_en = 2'b00;
    @(posedge clock);
    #1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 0) drive(2'b01, mk(9), '0, 1'b0);
      else          drive(2'b00, '0, '0, 1'b0);
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL flash_after c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL flash_after c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      commit(acc);
    end
  endtask

`ifdef RESULT_QUEUE_BYPASS_EN
  task automatic test_bypass();
    logic [N-1:0] acc;
    for (int cyc = 0; cyc < 5; cyc++) begin
      case (cyc)
        0:       drive(2'b01, mk(3), '0, 1'b0);
        2:       drive(2'b11, mk(4), mk(5), 1'b1);
        default: drive(2'b00, '0, '0, 1'b0);
      endcase
      n_checks++; if (c_en !== exp_cen) begin n_fail++; $display("FAIL bypass c_en cyc%0d: got %b want %b", cyc, c_en, exp_cen); end
      if (exp_cen) begin
        n_checks++; if (c_msg !== exp_cmsg) begin n_fail++; $display("FAIL bypass c_msg cyc%0d: got %h want %h", cyc, c_msg, exp_cmsg); end
      end
      commit(acc);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_ports();
    test_port_order();
    test_backpressure();
    test_wrap();
    test_flash();
`ifdef RESULT_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
